// File: rtl/llif_pkg.sv
// Shared types, default neuron constants and the saturating-add helper
// for the time-shared LLIF scheduler.
package llif_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam int unsigned LLIF_THRESHOLD = 200;
  localparam int unsigned LLIF_LEAK      = 1;
  localparam int unsigned LLIF_REFRAC    = 2;

  // Unsigned add clamped to max; callers narrow the result to their width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/llif_update_unit.sv
// Combinational single-neuron update: leak, integrate, threshold, fire,
// refractory. One instance is time-shared across all virtual neurons.
module llif_update_unit
  import llif_pkg::*;
#(
  parameter int unsigned W_POT     = 10,
  parameter int unsigned REF_W     = 2,
  parameter int unsigned THRESHOLD = LLIF_THRESHOLD,
  parameter int unsigned LEAK      = LLIF_LEAK,
  parameter int unsigned REFRAC    = LLIF_REFRAC
) (
  input  logic [W_POT-1:0] v,
  input  logic [W_POT-1:0] acc,
  input  logic [REF_W-1:0] rcnt,
  output logic [W_POT-1:0] v_next,
  output logic [REF_W-1:0] rcnt_next,
  output logic             fire
);

  localparam int unsigned VMAX = (2 ** W_POT) - 1;

  logic [W_POT-1:0] t;
  logic [W_POT-1:0] lv;

  always_comb begin
    fire      = 1'b0;
    v_next    = '0;
    rcnt_next = rcnt;
    t         = '0;
    lv        = '0;
    if (rcnt != '0) begin
      // refractory: potential held at zero, pending input discarded
      rcnt_next = rcnt - 1'b1;
    end else begin
      t  = W_POT'(sat_add(32'(v), 32'(acc), VMAX));
      lv = (32'(t) > LEAK) ? W_POT'(32'(t) - LEAK) : '0;
      if (32'(lv) >= THRESHOLD) begin
        fire      = 1'b1;
        rcnt_next = REF_W'(REFRAC);
      end else begin
        v_next = lv;
      end
    end
  end

endmodule

// File: rtl/llif_tdm_scheduler.sv
// Time-division LLIF scheduler: accumulates input events while idle, then
// sweeps every virtual neuron through one shared update unit per tick.
module llif_tdm_scheduler
  import llif_pkg::*;
#(
  parameter int unsigned N_NEURON  = 4,
  parameter int unsigned IDX_W     = $clog2(N_NEURON),
  parameter int unsigned W_IN      = 8,
  parameter int unsigned W_POT     = 10,
  parameter int unsigned THRESHOLD = LLIF_THRESHOLD,
  parameter int unsigned LEAK      = LLIF_LEAK,
  parameter int unsigned REFRAC    = LLIF_REFRAC
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IDX_W-1:0] i_in_idx,
  input  logic [W_IN-1:0]  i_in_weight,
  output logic             o_busy,
  output logic             o_spike_valid,
  output logic [IDX_W-1:0] o_spike_idx,
  output logic             o_done,
  output logic             o_tick_overrun
);

  localparam int unsigned REF_W = $clog2(REFRAC + 2);
  localparam int unsigned VMAX  = (2 ** W_POT) - 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;

  logic [W_POT-1:0] v_mem   [N_NEURON];
  logic [W_POT-1:0] acc_mem [N_NEURON];
  logic [REF_W-1:0] ref_mem [N_NEURON];

  logic             scan;
  logic             last;
  logic             idx_ok;
  logic             acc_we;
  logic [W_POT-1:0] acc_sum;
  logic [W_POT-1:0] upd_v;
  logic [REF_W-1:0] upd_ref;
  logic             upd_fire;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    o_in_ready = 1'b0;
    o_busy     = 1'b0;
    case (state_q)
      IDLE: begin
        o_in_ready = 1'b1;
        if (i_tick) begin
          state_d = SCAN;
          k_d     = '0;
        end
      end
      SCAN: begin
        o_busy = 1'b1;
        k_d    = k_q + 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign scan    = (state_q == SCAN);
  assign last    = (k_q == IDX_W'(N_NEURON - 1));
  assign idx_ok  = (32'(i_in_idx) < N_NEURON);
  assign acc_we  = i_in_valid && o_in_ready && idx_ok;
  assign acc_sum = W_POT'(sat_add(32'(acc_mem[i_in_idx]), 32'(i_in_weight), VMAX));

  llif_update_unit #(
    .W_POT    (W_POT),
    .REF_W    (REF_W),
    .THRESHOLD(THRESHOLD),
    .LEAK     (LEAK),
    .REFRAC   (REFRAC)
  ) u_update (
    .v        (v_mem[k_q]),
    .acc      (acc_mem[k_q]),
    .rcnt     (ref_mem[k_q]),
    .v_next   (upd_v),
    .rcnt_next(upd_ref),
    .fire     (upd_fire)
  );

  // Event writes happen only in IDLE and sweep writes only in SCAN,
  // so the two accumulator write ports never collide.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < N_NEURON; i++) begin
        v_mem[i]   <= '0;
        acc_mem[i] <= '0;
        ref_mem[i] <= '0;
      end
      o_spike_valid  <= 1'b0;
      o_spike_idx    <= '0;
      o_done         <= 1'b0;
      o_tick_overrun <= 1'b0;
    end else begin
      if (acc_we) acc_mem[i_in_idx] <= acc_sum;
      if (scan) begin
        v_mem[k_q]   <= upd_v;
        ref_mem[k_q] <= upd_ref;
        acc_mem[k_q] <= '0;
      end
      o_spike_valid  <= scan && upd_fire;
      o_spike_idx    <= (scan && upd_fire) ? k_q : '0;
      o_done         <= scan && last;
      o_tick_overrun <= i_tick && (state_q != IDLE);
    end
  end

endmodule

// File: doc/llif_tdm_scheduler.md
Name: llif_tdm_scheduler

Overview:
- Time-division scheduler that shares one LLIF update datapath among N_NEURON virtual neurons.
- Collects weighted input events between timesteps into per-neuron accumulators.
- On each timestep tick, sweeps the neurons one per cycle: leak, integrate, threshold, fire, refractory.
- Emits an indexed spike stream. Sits between the input spike fabric and downstream spike routing.

Parameters:
- N_NEURON, 4, number of virtual neurons (power of 2, ≥2)
- IDX_W, $clog2(N_NEURON), neuron index width
- W_IN, 8, input weight width
- W_POT, 10, membrane potential and accumulator width (unsigned)
- THRESHOLD, 200, firing threshold (potential ≥ THRESHOLD fires)
- LEAK, 1, constant subtracted per timestep
- REFRAC, 2, refractory timesteps after a spike

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_tick  in  1  timestep start request (single-cycle pulse)
- i_in_valid  in  1  input event valid
- o_in_ready  out  1  input event ready
- i_in_idx  in  IDX_W  target neuron of the event
- i_in_weight  in  W_IN  event weight (unsigned)
- o_busy  out  1  sweep in progress
- o_spike_valid  out  1  spike output valid (one cycle per spike)
- o_spike_idx  out  IDX_W  index of the firing neuron
- o_done  out  1  one-cycle pulse: sweep finished
- o_tick_overrun  out  1  one-cycle pulse: tick arrived while not IDLE

Behaviour:
- Reset (async): state IDLE; all potentials, accumulators and refractory counters 0; o_in_ready=1; all other outputs 0. Reset mid-sweep aborts the sweep; no o_done is produced.
- States:
  - IDLE: o_in_ready=1. Event accepted on valid&ready: acc[idx] = sat(acc[idx]+weight) at 2^W_POT-1. Event with idx ≥ N_NEURON is accepted and dropped. i_tick → SCAN with scan index 0.
  - SCAN: o_in_ready=0, o_busy=1. One neuron per cycle, scan index k = 0..N-1. After k = N-1 → DONE.
  - DONE: one cycle, then → IDLE.
- Update per neuron k:
  - If ref[k] > 0: ref[k]--, v[k]=0, acc[k] discarded.
  - Else t = v[k]+acc[k] saturated at 2^W_POT-1, then v = t-LEAK floored at 0.
  - If v ≥ THRESHOLD: spike, v[k]=0, ref[k]=REFRAC. Otherwise v[k]=v.
  - acc[k] is cleared in all cases.
- Timing (E0 = edge that samples i_tick):
  - Neuron k is updated at edge E(k+1). The spike is registered at that edge, so o_spike_valid/o_spike_idx=k are visible in the following cycle.
  - o_done is registered at E(N), coincident with the spike slot of neuron N-1.
  - o_in_ready returns to 1 after E(N+1).
- Simultaneous events:
  - An event and i_tick in the same IDLE cycle: the event is accepted and included in this sweep.
  - i_tick in SCAN or DONE: ignored; o_tick_overrun pulses the next cycle.
  - i_in_valid while ready=0: the source holds its data (valid/ready rule); no loss.
- o_spike_idx = 0 whenever o_spike_valid = 0.

Decomposition:
- Package llif_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - default constants for THRESHOLD, LEAK and REFRAC;
  - a saturating-add helper function.
- One sub-module is natural: llif_update_unit. It is the combinational single-neuron update (v, acc, ref in → v', ref', fire out), instantiated once and time-shared.
- Potential, accumulator and refractory storage plus the FSM stay in the top level.

Test Plan (N=4, THRESHOLD=200, LEAK=1, REFRAC=2, W_POT=10):
- Reset: assert i_rst mid-cycle → all outputs 0 immediately, o_in_ready=1 after release.
- Integrate: weights 60, 50, 80, 60 to idx0, one tick after each → v0 = 59, 108, 187. The fourth tick gives o_spike_valid with idx 0 in the cycle after E1, and v0=0.
- Refractory: 250 to idx2 + tick → spike idx2 (cycle after E3). Repeat 250 + tick twice → no spike. Third repeat → spike idx2.
- Saturation: five events of 255 to idx1 → acc clamps at 1023. Tick → spike idx1.
- Overrun/backpressure: tick at E0, second tick at E2 → o_tick_overrun pulse, no extra sweep. Event presented during SCAN stays pending (ready=0), is accepted after E5, and applies to the next sweep.
- Sweep timing: tick with no spikes → o_busy high 4 cycles, o_done after E4, o_in_ready=1 after E5.
